// File: rtl/box_filter_ctrl.sv
// box_filter_ctrl: raster-to-3x3-window sequencer for box_filter with zero padding and frame control.
module box_filter_ctrl #(
  parameter int MAX_WIDTH  = 320,
  parameter int MAX_HEIGHT = 240,
  parameter int COL_W      = $clog2(MAX_WIDTH + 1),
  parameter int ROW_W      = $clog2(MAX_HEIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [COL_W-1:0] frame_width,
  input  logic [ROW_W-1:0] frame_height,
  input  logic [3:0]       neighbors_cfg,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [8:0]       win_map,
  output logic [3:0]       win_neighbors,
  output logic             win_enable,
  input  logic             filt_motion,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
  state_t state;
  logic [COL_W-1:0] w, c, cc;
  logic [ROW_W-1:0] h, cr;
  logic [ROW_W:0] r;
  logic fin, win_last;
  logic [2:0] cl, cm, col_new, row_mask, col_mask;
  logic [2:0][2:0] cols;
  logic [8:0] win_next;
  logic lb_a [MAX_WIDTH];
  logic lb_b [MAX_WIDTH];
  logic accept, step, issue, px, c_wrap, cc_wrap, last_centre, legal;
  assign accept = in_valid && state == STREAM;
  // FLUSH keeps the pipeline moving by shifting in zero pixels below the frame
  assign step = accept || (state == FLUSH && !fin);
  assign px = accept && in_bit;
  assign col_new = {px, lb_a[c], lb_b[c]};
  assign issue = step && (r[ROW_W:1] != '0 || (r[0] && c != '0));
  assign c_wrap = c == w - COL_W'(1);
  assign cc_wrap = cc == w - COL_W'(1);
  assign last_centre = cc_wrap && cr == h - ROW_W'(1);
  assign legal = frame_width >= COL_W'(3) && frame_width <= COL_W'(MAX_WIDTH) &&
                 frame_height >= ROW_W'(3) && frame_height <= ROW_W'(MAX_HEIGHT) &&
                 neighbors_cfg <= 4'd8;
  // masks follow the centre position, so stale row-wrap taps never reach the window
  assign row_mask = {cr != h - ROW_W'(1), 1'b1, cr != '0};
  assign col_mask = {!cc_wrap, 1'b1, cc != '0};
  assign cols = {col_new, cm, cl};
  always_comb begin
    win_next = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_next[3*i+j] = cols[j][i] & row_mask[i] & col_mask[j];
  end
  assign in_ready = state == STREAM;
  assign busy = state != IDLE;
  assign done = out_last;
  assign out_bit = out_valid && filt_motion;
  always_ff @(posedge clk) begin
    if (step) begin
      lb_a[c] <= px;
      lb_b[c] <= lb_a[c];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w <= '0;
      h <= '0;
      c <= '0;
      r <= '0;
      cc <= '0;
      cr <= '0;
      cl <= '0;
      cm <= '0;
      fin <= 1'b0;
      win_map <= '0;
      win_neighbors <= '0;
      win_enable <= 1'b0;
      win_last <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      win_enable <= issue;
      win_map <= issue ? win_next : '0;
      win_last <= issue && last_centre;
      out_valid <= win_enable;
      out_last <= win_last;
      if (step) begin
        c <= c_wrap ? '0 : c + COL_W'(1);
        r <= c_wrap ? r + (ROW_W+1)'(1) : r;
        cl <= cm;
        cm <= col_new;
      end
      if (issue) begin
        cc <= cc_wrap ? '0 : cc + COL_W'(1);
        cr <= cc_wrap ? cr + ROW_W'(1) : cr;
      end
      case (state)
        IDLE: if (start) begin
          if (legal) begin
            state <= STREAM;
            w <= frame_width;
            h <= frame_height;
            win_neighbors <= neighbors_cfg;
            c <= '0;
            r <= '0;
            cc <= '0;
            cr <= '0;
            fin <= 1'b0;
          end else cfg_err <= 1'b1;
        end
        STREAM: if (accept && c_wrap && r == {1'b0, h - ROW_W'(1)}) state <= FLUSH;
        FLUSH: begin
          if (fin) state <= DRAIN;
          else if (issue && last_centre) fin <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
